// File: rtl/x_mem_resp_if.sv
// Request/accept bus between the rv32i core (master) and the word memory responder (slave).
interface x_mem_resp_if;
   logic        i_valid;
   logic        i_rnw;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        o_accept;
   logic [31:0] o_data;
   logic        o_err;

   modport master (
      output i_valid, i_rnw, i_addr, i_data,
      input  o_accept, o_data, o_err
   );

   modport slave (
      input  i_valid, i_rnw, i_addr, i_data,
      output o_accept, o_data, o_err
   );
endinterface

// File: rtl/x_mem_resp.sv
// Single-port word memory responder with programmable wait states and a one-cycle accept.
// Define X_MEM_RESP_PROT_EN to write-protect words 0..RO_WORDS-1.
module x_mem_resp #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned WAIT     = 1,
   parameter int unsigned RO_WORDS = 256
) (
   input logic         i_clk,
   input logic         i_nrst,
   x_mem_resp_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

   state_e        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          rnw_q, rnw_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          oor_q, oor_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q;
   logic [31:0]   mem_q [DEPTH];

   logic req_oor;
   logic req_prot;
   logic unused_addr;

   assign req_oor     = |bus.i_addr[31:AW+2];
   assign unused_addr = ^bus.i_addr[1:0];

`ifdef X_MEM_RESP_PROT_EN
   assign req_prot = !bus.i_rnw && ({1'b0, bus.i_addr[AW+1:2]} < (AW+1)'(RO_WORDS));
`else
   logic unused_ro;
   assign req_prot  = 1'b0;
   assign unused_ro = (RO_WORDS == 0);
`endif

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Request fields are captured only in IDLE, so a held i_valid in ACK is ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rnw_d   = rnw_q;
      wdata_d = wdata_q;
      oor_d   = oor_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               idx_d   = bus.i_addr[AW+1:2];
               rnw_d   = bus.i_rnw;
               wdata_d = bus.i_data;
               oor_d   = req_oor;
               err_d   = req_oor | req_prot;
               cnt_d   = 8'(WAIT);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) state_d = ACK;
            else             cnt_d   = cnt_q - 8'd1;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         rnw_q   <= 1'b1;
         wdata_q <= '0;
         oor_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rnw_q   <= rnw_d;
         wdata_q <= wdata_d;
         oor_q   <= oor_d;
         err_q   <= err_d;
         if (state_q == BUSY) rdata_q <= oor_q ? '0 : mem_q[idx_q];
      end
   end

   // err_q also covers protected writes, so it gates the commit; the array is never reset.
   always_ff @(posedge i_clk) begin
      if (state_q == ACK && !rnw_q && !err_q) mem_q[idx_q] <= wdata_q;
   end

   always_comb begin
      bus.o_accept = 1'b0;
      bus.o_data   = '0;
      bus.o_err    = 1'b0;
      if (state_q == ACK) begin
         bus.o_accept = 1'b1;
         bus.o_data   = rnw_q ? rdata_q : '0;
         bus.o_err    = err_q;
      end
   end
endmodule
